// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned, debounced matrix keypad encoder.
// One debounced press -> one key index over a valid/ready handshake.
module keypad_scanner #(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 3,
  parameter  int SETTLE   = 2,
  parameter  int DEBOUNCE = 4,
  localparam int KW       = $clog2(ROWS*COLS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [ROWS-1:0] rows,
  output logic [COLS-1:0] col_drive,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [KW-1:0]   key_code,
  output logic            key_down,
  output logic            overflow,
  input  logic            clr_overflow
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEB,
    HELD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ROWS-1:0] r_meta;
  logic [ROWS-1:0] r_rs;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   w_col_nxt;
  logic [CW-1:0]   w_col_inc;
  logic [SW-1:0]   r_settle;
  logic [SW-1:0]   w_settle_nxt;
  logic [DW-1:0]   r_cnt;
  logic [DW-1:0]   w_cnt_nxt;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   w_row_nxt;
  logic [RW-1:0]   w_hit_row;
  logic [ROWS-1:0] r_row_oh;
  logic [ROWS-1:0] w_row_oh_nxt;
  logic            w_hit;
  logic            w_emit;
  logic            w_drop;
  logic            w_down_nxt;
  logic [KW-1:0]   w_code;
  logic [COLS-1:0] r_col_drive;
  logic            r_valid;
  logic [KW-1:0]   r_code;
  logic            r_down;
  logic            r_ovf;

  assign w_hit     = ($countones(r_rs) == 1);
  assign w_col_inc = (r_col == CW'(COLS-1)) ? '0 : r_col + 1'b1;
  assign w_code    = KW'(r_row) * KW'(COLS) + KW'(r_col);
  assign w_drop    = w_emit & r_valid & ~key_ready;

  // Index of the set row bit (meaningful only on a single hit).
  always_comb begin
    w_hit_row = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r_rs[i]) w_hit_row = RW'(i);
    end
  end

  // Scan / debounce / hold next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_settle_nxt = r_settle;
    w_cnt_nxt    = r_cnt;
    w_row_nxt    = r_row;
    w_row_oh_nxt = r_row_oh;
    w_down_nxt   = r_down;
    w_emit       = 1'b0;
    unique case (r_state)
      SCAN: begin
        if (r_settle == SW'(SETTLE-1)) begin
          w_settle_nxt = '0;
          if (w_hit) begin
            w_state_nxt  = DEB;
            w_row_nxt    = w_hit_row;
            w_row_oh_nxt = r_rs;
            w_cnt_nxt    = '0;
          end else begin
            w_col_nxt = w_col_inc;
          end
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      DEB: begin
        if (r_rs != r_row_oh) begin
          w_state_nxt  = SCAN;
          w_col_nxt    = w_col_inc;
          w_settle_nxt = '0;
        end else if (r_cnt == DW'(DEBOUNCE-1)) begin
          w_state_nxt = HELD;
          w_emit      = 1'b1;
          w_down_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (r_rs != '0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DW'(DEBOUNCE-1)) begin
          w_state_nxt  = SCAN;
          w_down_nxt   = 1'b0;
          w_col_nxt    = w_col_inc;
          w_settle_nxt = '0;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  // State, synchroniser and column drive registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SCAN;
      r_meta      <= '0;
      r_rs        <= '0;
      r_col       <= '0;
      r_settle    <= '0;
      r_cnt       <= '0;
      r_row       <= '0;
      r_row_oh    <= '0;
      r_down      <= 1'b0;
      r_col_drive <= COLS'(1);
    end else begin
      r_state     <= w_state_nxt;
      r_meta      <= rows;
      r_rs        <= r_meta;
      r_col       <= w_col_nxt;
      r_settle    <= w_settle_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row       <= w_row_nxt;
      r_row_oh    <= w_row_oh_nxt;
      r_down      <= w_down_nxt;
      r_col_drive <= COLS'(1) << w_col_nxt;
    end
  end

  // Output handshake: refill on emit, drop into overflow when stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_emit && !w_drop) begin
        r_code  <= w_code;
        r_valid <= 1'b1;
      end else if (r_valid && key_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_overflow) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign col_drive = r_col_drive;
  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_down  = r_down;
  assign overflow  = r_ovf;

endmodule
